// File: rtl/ram_arb_pkg.sv
// Shared types and sizing helpers for the sdram user-port arbiter.
// Imported by the arbiter top and its round-robin picker.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RD,
    GAP
  } state_t;

  localparam int ADDR_W_DEF = 24;
  localparam int DATA_W_DEF = 16;

  function automatic int cnt_w(input int t);
    return (t < 2) ? 1 : $clog2(t + 1);
  endfunction

endpackage

// File: rtl/ram_arbiter_rr.sv
// Combinational round-robin picker: searches req from ptr upward, wrapping.
// The pointer register itself lives in the arbiter top.
module rr_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int PW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] winner,
  output logic            valid
);

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!valid && req[(int'(ptr) + i) % NREQ]) begin
        winner[(int'(ptr) + i) % NREQ] = 1'b1;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares the sdram_block user port between NREQ requesters, round-robin,
// one transaction in flight, all outputs registered.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          req_we,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          grant,
  output logic [NREQ-1:0]          rd_valid,
  output logic                     rd_err,
  output logic [DATA_W-1:0]        rd_data,
  output logic [ADDR_W-1:0]        ram_addr,
  output logic [DATA_W-1:0]        ram_wr_data,
  output logic                     ram_wr_en,
  output logic                     ram_rd_en,
  input  logic                     ram_busy,
  input  logic                     ram_rd_ready,
  input  logic [DATA_W-1:0]        ram_rd_data,
  output logic                     ram_rd_ack
);

  localparam int PW = (NREQ > 2) ? $clog2(NREQ) : 1;
  localparam int CW = cnt_w(TIMEOUT);

  state_t            state;
  logic [PW-1:0]     ptr;
  logic [NREQ-1:0]   owner;
  logic              we;
  logic [CW-1:0]     cnt;

  logic [NREQ-1:0]   win;
  logic              win_valid;
  logic [PW-1:0]     sel_idx;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [PW-1:0]     next_ptr;

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr (
    .req    (req),
    .ptr    (ptr),
    .winner (win),
    .valid  (win_valid)
  );

  always_comb begin
    sel_idx   = '0;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win[i]) begin
        sel_idx   = PW'(i);
        sel_we    = req_we[i];
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign next_ptr = (sel_idx == PW'(NREQ - 1)) ? '0
                  : sel_idx + PW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      owner       <= '0;
      we          <= 1'b0;
      cnt         <= '0;
      grant       <= '0;
      rd_valid    <= '0;
      rd_err      <= 1'b0;
      rd_data     <= '0;
      ram_addr    <= '0;
      ram_wr_data <= '0;
      ram_wr_en   <= 1'b0;
      ram_rd_en   <= 1'b0;
      ram_rd_ack  <= 1'b0;
    end else begin
      grant      <= '0;
      rd_valid   <= '0;
      rd_err     <= 1'b0;
      ram_wr_en  <= 1'b0;
      ram_rd_en  <= 1'b0;
      ram_rd_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          // command pulses are registered on entry so they show in ISSUE
          if (win_valid && !ram_busy) begin
            owner       <= win;
            we          <= sel_we;
            ptr         <= next_ptr;
            grant       <= win;
            ram_addr    <= sel_addr;
            ram_wr_data <= sel_wdata;
            ram_wr_en   <= sel_we;
            ram_rd_en   <= !sel_we;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= we ? GAP : WAIT_RD;
        end
        WAIT_RD: begin
          if (ram_rd_ready) begin
            rd_data    <= ram_rd_data;
            rd_valid   <= owner;
            ram_rd_ack <= 1'b1;
            state      <= GAP;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            rd_data  <= '0;
            rd_valid <= owner;
            rd_err   <= 1'b1;
            state    <= GAP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        GAP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural sdram_block with programmable
// busy/read delay, rr reference model and randomized traffic.
module tb_ram_arbiter;

  localparam int NREQ = 2;
  localparam int AW   = 24;
  localparam int DW   = 16;
  localparam int TO   = 16;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   req_we;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   rd_valid;
  logic              rd_err;
  logic [DW-1:0]     rd_data;
  logic [AW-1:0]     ram_addr;
  logic [DW-1:0]     ram_wr_data;
  logic              ram_wr_en;
  logic              ram_rd_en;
  logic              ram_busy;
  wire               ram_rd_ready;
  logic [DW-1:0]     ram_rd_data;
  logic              ram_rd_ack;

  logic mdl_rdy;
  logic stray_rdy;
  assign ram_rd_ready = mdl_rdy | stray_rdy;

  int errors = 0;
  int checks = 0;

  ram_arbiter #(
    .NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .grant(grant), .rd_valid(rd_valid), .rd_err(rd_err),
    .rd_data(rd_data), .ram_addr(ram_addr),
    .ram_wr_data(ram_wr_data), .ram_wr_en(ram_wr_en),
    .ram_rd_en(ram_rd_en), .ram_busy(ram_busy),
    .ram_rd_ready(ram_rd_ready), .ram_rd_data(ram_rd_data),
    .ram_rd_ack(ram_rd_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // sdram model state and observation logs
  logic [DW-1:0] mem [logic [AW-1:0]];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  int rd_delay = 0;
  int pend = 0;
  int cyc = 0;
  int gnt_cyc[$];
  int rdv_n = 0;
  int ack_n = 0;
  int wr_n = 0;
  int rden_n = 0;
  int m_ptr = 0;

  function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
    return a[DW-1:0] ^ 16'hA5C3;
  endfunction

  function automatic int oh2i(input logic [NREQ-1:0] v);
    if (v == 2'b01) return 0;
    if (v == 2'b10) return 1;
    return -1;
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
    for (int i = 0; i < NREQ; i++)
      if (r[(p + i) % NREQ]) return (p + i) % NREQ;
    return -1;
  endfunction

  initial begin
    mdl_rdy = 1'b0;
    ram_rd_data = '0;
    forever begin
      @(negedge clk);
      cyc++;
      mdl_rdy = 1'b0;
      if (|grant) gnt_cyc.push_back(cyc);
      if (|rd_valid) rdv_n++;
      if (ram_rd_ack) ack_n++;
      if (ram_wr_en) begin
        mem[ram_addr] = ram_wr_data;
        wr_n++;
      end
      if (ram_rd_en) rden_n++;
      if (rst) pend = 0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          mdl_rdy = 1'b1;
          ram_rd_data = mem.exists(ram_addr) ? mem[ram_addr]
                                             : dflt(ram_addr);
        end
      end
      if (ram_rd_en && rd_delay > 0) pend = rd_delay;
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic clear_logs();
    gnt_cyc.delete();
    rdv_n = 0; ack_n = 0; wr_n = 0; rden_n = 0;
  endtask

  task automatic set_req(input int i, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i] = 1'b1;
    req_we[i] = we;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic wait_grant(input int n, output bit ok);
    ok = 0;
    for (int t = 0; t < n; t++) begin
      @(negedge clk);
      if (|grant) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL grant_wait: no grant within %0d cycles", n);
    end
  endtask

  task automatic wait_rdv(input int n, output bit ok, output int waited);
    ok = 0;
    waited = 0;
    for (int t = 0; t < n; t++) begin
      @(negedge clk);
      waited++;
      if (|rd_valid) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rdv_wait: no rd_valid within %0d cycles", n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    checks++;
    if ({grant, rd_valid, rd_err, ram_wr_en, ram_rd_en, ram_rd_ack} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 0",
               {grant, rd_valid, rd_err, ram_wr_en, ram_rd_en, ram_rd_ack});
    end
    checks++;
    if ({ram_addr, ram_wr_data, rd_data} !== '0) begin
      errors++;
      $display("FAIL reset_data: addr %h wdata %h rdata %h expected 0",
               ram_addr, ram_wr_data, rd_data);
    end
    req = 2'b11;
    tick(2);
    checks++;
    if (grant !== 2'b00 || ram_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: grant %b rd_en %b expected 0", grant, ram_rd_en);
    end
    req = 2'b00;
    rst = 1'b0;
    m_ptr = 0;
    tick(2);
  endtask

  task automatic test_fairness();
    bit ok;
    int exp;
    clear_logs();
    set_req(0, 1'b1, 24'h000200, 16'h1111);
    set_req(1, 1'b1, 24'h000300, 16'h2222);
    for (int k = 0; k < 4; k++) begin
      wait_grant(10, ok);
      if (ok) begin
        exp = rr_pick(2'b11, m_ptr);
        m_ptr = (exp + 1) % NREQ;
        checks++;
        if (oh2i(grant) !== exp) begin
          errors++;
          $display("FAIL fair_order[%0d]: grant %b expected idx %0d", k, grant, exp);
        end
        checks++;
        if (ram_wr_en !== 1'b1 ||
            ram_addr !== (exp == 0 ? 24'h000200 : 24'h000300)) begin
          errors++;
          $display("FAIL fair_cmd[%0d]: wr_en %b addr %h", k, ram_wr_en, ram_addr);
        end
      end
    end
    req = 2'b00;
    tick(6);
    checks++;
    if (gnt_cyc.size() != 4 || wr_n != 4) begin
      errors++;
      $display("FAIL fair_count: grants %0d writes %0d expected 4",
               gnt_cyc.size(), wr_n);
    end
    for (int k = 1; k < gnt_cyc.size(); k++) begin
      checks++;
      if (gnt_cyc[k] - gnt_cyc[k-1] < 3) begin
        errors++;
        $display("FAIL fair_spacing: gap %0d expected >= 3",
                 gnt_cyc[k] - gnt_cyc[k-1]);
      end
    end
  endtask

  task automatic test_single_read();
    bit ok;
    int w;
    clear_logs();
    mem[24'h000123] = 16'hBEEF;
    rd_delay = 5;
    set_req(0, 1'b0, 24'h000123, 16'h0000);
    wait_grant(10, ok);
    req = 2'b00;
    if (ok) begin
      m_ptr = 1;
      checks++;
      if (ram_rd_en !== 1'b1 || ram_addr !== 24'h000123 || ram_wr_en !== 1'b0) begin
        errors++;
        $display("FAIL read_cmd: rd_en %b wr_en %b addr %h expected 1 0 000123",
                 ram_rd_en, ram_wr_en, ram_addr);
      end
    end
    wait_rdv(20, ok, w);
    if (ok) begin
      checks++;
      if (rd_valid !== 2'b01 || rd_data !== 16'hBEEF || rd_err !== 1'b0) begin
        errors++;
        $display("FAIL read_data: valid %b data %h err %b expected 01 beef 0",
                 rd_valid, rd_data, rd_err);
      end
      checks++;
      if (ram_rd_ack !== 1'b1) begin
        errors++;
        $display("FAIL read_ack: ack %b expected 1 with rd_valid", ram_rd_ack);
      end
    end
    tick(5);
    checks++;
    if (rden_n != 1 || ack_n != 1 || rdv_n != 1) begin
      errors++;
      $display("FAIL read_pulses: rd_en %0d ack %0d rdv %0d expected 1 1 1",
               rden_n, ack_n, rdv_n);
    end
  endtask

  task automatic test_busy();
    bit ok;
    clear_logs();
    ram_busy = 1'b1;
    set_req(1, 1'b1, 24'h00ABCD, 16'h1234);
    tick(10);
    checks++;
    if (wr_n != 0 || rden_n != 0 || gnt_cyc.size() != 0) begin
      errors++;
      $display("FAIL busy_block: wr %0d rd %0d grants %0d expected 0",
               wr_n, rden_n, gnt_cyc.size());
    end
    ram_busy = 1'b0;
    wait_grant(5, ok);
    req = 2'b00;
    if (ok) begin
      m_ptr = 0;
      checks++;
      if (grant !== 2'b10 || ram_wr_en !== 1'b1 ||
          ram_addr !== 24'h00ABCD || ram_wr_data !== 16'h1234) begin
        errors++;
        $display("FAIL busy_write: grant %b wr_en %b addr %h data %h",
                 grant, ram_wr_en, ram_addr, ram_wr_data);
      end
    end
    tick(4);
    checks++;
    if (wr_n != 1) begin
      errors++;
      $display("FAIL busy_count: writes %0d expected 1", wr_n);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int w;
    clear_logs();
    rd_delay = 0;
    set_req(0, 1'b0, 24'h000077, 16'h0000);
    wait_grant(10, ok);
    req = 2'b00;
    m_ptr = 1;
    wait_rdv(40, ok, w);
    if (ok) begin
      checks++;
      if (rd_valid !== 2'b01 || rd_err !== 1'b1 || rd_data !== 16'h0000) begin
        errors++;
        $display("FAIL timeout_resp: valid %b err %b data %h expected 01 1 0000",
                 rd_valid, rd_err, rd_data);
      end
      checks++;
      if (w != TO + 1) begin
        errors++;
        $display("FAIL timeout_lat: grant to rd_valid %0d expected %0d", w, TO + 1);
      end
    end
    tick(4);
    checks++;
    if (ack_n != 0) begin
      errors++;
      $display("FAIL timeout_ack: ack count %0d expected 0", ack_n);
    end
  endtask

  task automatic test_stray_ready();
    clear_logs();
    tick(2);
    stray_rdy = 1'b1;
    tick(1);
    stray_rdy = 1'b0;
    tick(4);
    checks++;
    if (rdv_n != 0 || ack_n != 0) begin
      errors++;
      $display("FAIL stray_ready: rdv %0d ack %0d expected 0 0", rdv_n, ack_n);
    end
  endtask

  task automatic test_rst_mid();
    bit ok;
    int w;
    rd_delay = 0;
    set_req(1, 1'b0, 24'h000055, 16'h0000);
    wait_grant(10, ok);
    req = 2'b00;
    tick(3);
    rst = 1'b1;
    tick(1);
    checks++;
    if ({grant, rd_valid, rd_err, ram_wr_en, ram_rd_en, ram_rd_ack,
         ram_addr, ram_wr_data, rd_data} !== '0) begin
      errors++;
      $display("FAIL rst_mid: addr %h valid %b ack %b expected all 0",
               ram_addr, rd_valid, ram_rd_ack);
    end
    rst = 1'b0;
    m_ptr = 0;
    clear_logs();
    mem[24'h000010] = 16'hCAFE;
    rd_delay = 3;
    set_req(0, 1'b0, 24'h000010, 16'h0000);
    set_req(1, 1'b0, 24'h000011, 16'h0000);
    wait_grant(10, ok);
    req = 2'b00;
    if (ok) begin
      checks++;
      if (grant !== 2'b01) begin
        errors++;
        $display("FAIL rst_grant: grant %b expected 01", grant);
      end
      m_ptr = 1;
    end
    wait_rdv(20, ok, w);
    if (ok) begin
      checks++;
      if (rd_valid !== 2'b01 || rd_data !== 16'hCAFE || rd_err !== 1'b0) begin
        errors++;
        $display("FAIL rst_read: valid %b data %h err %b expected 01 cafe 0",
                 rd_valid, rd_data, rd_err);
      end
    end
    tick(4);
    checks++;
    if (rdv_n != 1 || ack_n != 1) begin
      errors++;
      $display("FAIL rst_pulses: rdv %0d ack %0d expected 1 1", rdv_n, ack_n);
    end
  endtask

  task automatic test_random();
    bit ok;
    int w, exp, nrd, bw;
    logic [NREQ-1:0] pat;
    logic [AW-1:0] a [NREQ];
    logic [DW-1:0] d [NREQ];
    logic wv [NREQ];
    logic [DW-1:0] ed;
    clear_logs();
    nrd = 0;
    for (int n = 0; n < 30; n++) begin
      pat = NREQ'($urandom_range(1, 3));
      for (int i = 0; i < NREQ; i++) begin
        a[i]  = AW'($urandom_range(0, 15));
        d[i]  = DW'($urandom);
        wv[i] = 1'($urandom_range(0, 1));
        if (pat[i]) set_req(i, wv[i], a[i], d[i]);
      end
      rd_delay = $urandom_range(1, 6);
      if ($urandom_range(0, 3) == 0) begin
        ram_busy = 1'b1;
        bw = $urandom_range(1, 4);
        for (int t = 0; t < bw; t++) begin
          tick(1);
          checks++;
          if (grant !== 2'b00) begin
            errors++;
            $display("FAIL rand_busy[%0d]: grant %b expected 00", n, grant);
          end
        end
        ram_busy = 1'b0;
      end
      wait_grant(10, ok);
      req = 2'b00;
      if (!ok) continue;
      exp = rr_pick(pat, m_ptr);
      m_ptr = (exp + 1) % NREQ;
      checks++;
      if (oh2i(grant) !== exp) begin
        errors++;
        $display("FAIL rand_grant[%0d]: grant %b expected idx %0d", n, grant, exp);
        tick(TO + 4);
        continue;
      end
      checks++;
      if (ram_addr !== a[exp] || ram_wr_en !== wv[exp] || ram_rd_en !== !wv[exp]) begin
        errors++;
        $display("FAIL rand_cmd[%0d]: addr %h wr %b rd %b expected %h %b",
                 n, ram_addr, ram_wr_en, ram_rd_en, a[exp], wv[exp]);
      end
      if (wv[exp]) begin
        ref_mem[a[exp]] = d[exp];
        checks++;
        if (ram_wr_data !== d[exp]) begin
          errors++;
          $display("FAIL rand_wdata[%0d]: %h expected %h", n, ram_wr_data, d[exp]);
        end
        tick(2);
      end else begin
        nrd++;
        ed = ref_mem.exists(a[exp]) ? ref_mem[a[exp]] : dflt(a[exp]);
        wait_rdv(20, ok, w);
        if (ok) begin
          checks++;
          if (oh2i(rd_valid) !== exp || rd_data !== ed || rd_err !== 1'b0) begin
            errors++;
            $display("FAIL rand_read[%0d]: valid %b data %h err %b expected idx %0d data %h",
                     n, rd_valid, rd_data, rd_err, exp, ed);
          end
        end
        tick(1);
      end
    end
    tick(4);
    checks++;
    if (ack_n != nrd || rdv_n != nrd) begin
      errors++;
      $display("FAIL rand_acks: ack %0d rdv %0d expected %0d", ack_n, rdv_n, nrd);
    end
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    req_we = '0;
    req_addr = '0;
    req_wdata = '0;
    ram_busy = 1'b0;
    stray_rdy = 1'b0;
    test_reset();
    test_fairness();
    test_single_read();
    test_busy();
    test_timeout();
    test_stray_ready();
    test_rst_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
